opp_packet_decoder: RTL and testbench

OPP_PACKET_DECODER -- requirements
Module: opp_packet_decoder

---
 rtl/opp_packet_decoder.sv | 155 +++++++++++++++
 tb/tb_opp_packet_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opp_packet_decoder.sv
// Opponent-state packet decoder: validates 44-bit payloads, holds the
// latest fields and tracks link liveness and reset-request confirmation.
module opp_packet_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned RESET_CONFIRM  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        axiov,
  input  logic [43:0] axiod,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_valid,
  output logic        link_lost,
  output logic        new_pulse,
  output logic        opp_reset_req,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    NO_LINK = 2'd0,
    LINKED  = 2'd1,
    LOST    = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RC = 3'(RESET_CONFIRM);

  state_t        state_q, state_d;
  logic [CW-1:0] sil_q, sil_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic [8:0]    dir_q, dir_d;
  logic [2:0]    game_q, game_d;
  logic          new_q, new_d;
  logic          rreq_q, rreq_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [7:0]    err_q, err_d;
  logic [2:0]    streak_q, streak_d;
  logic          armed_q, armed_d;

  logic [10:0] px, py;
  logic [8:0]  pd;
  logic [2:0]  pg;
  logic        pf, resv_ok, ok, acc, rej;
  logic [2:0]  s_inc;

  assign px = axiod[43:33];
  assign py = axiod[31:21];
  assign pd = axiod[19:11];
  assign pg = axiod[7:5];
  assign pf = axiod[3];

  assign resv_ok = ~|{axiod[32], axiod[20], axiod[10:8],
                      axiod[4], axiod[2:0]};
  assign ok  = resv_ok && !px[10] && (py < 11'd768)
               && (pd < 9'd360);
  assign acc = axiov && ok;
  assign rej = axiov && !ok;

  always_comb begin
    state_d  = state_q;
    sil_d    = sil_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    game_d   = game_q;
    new_d    = 1'b0;
    rreq_d   = 1'b0;
    pkt_d    = pkt_q;
    err_d    = err_q;
    streak_d = streak_q;
    armed_d  = armed_q;
    s_inc    = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;

    unique case (state_q)
      NO_LINK: if (acc) state_d = LINKED;
      LINKED:  if (!acc && sil_q == TLAST) state_d = LOST;
      LOST:    if (acc) state_d = LINKED;
      default: state_d = NO_LINK;
    endcase

    if (acc) begin
      sil_d = '0;
    end else if (state_q == LINKED && sil_q != TLAST) begin
      sil_d = sil_q + 1'b1;
    end

    if (acc) begin
      new_d  = {px, py, pd, pg} != {x_q, y_q, dir_q, game_q};
      x_d    = px;
      y_d    = py;
      dir_d  = pd;
      game_d = pg;
      pkt_d  = pkt_q + 16'd1;
      if (pf) begin
        streak_d = s_inc;
        if (armed_q && s_inc >= RC) begin
          rreq_d  = 1'b1;
          armed_d = 1'b0;
        end
      end else begin
        streak_d = '0;
        armed_d  = 1'b1;
      end
    end

    if (rej && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q  <= NO_LINK;
      sil_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= '0;
      game_q   <= '0;
      new_q    <= 1'b0;
      rreq_q   <= 1'b0;
      pkt_q    <= '0;
      err_q    <= '0;
      streak_q <= '0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sil_q    <= sil_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      game_q   <= game_d;
      new_q    <= new_d;
      rreq_q   <= rreq_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      armed_q  <= armed_d;
    end
  end

  assign opp_x         = x_q;
  assign opp_y         = y_q;
  assign opp_dir       = dir_q;
  assign opp_game      = game_q;
  assign opp_valid     = (state_q == LINKED);
  assign link_lost     = (state_q == LOST);
  assign new_pulse     = new_q;
  assign opp_reset_req = rreq_q;
  assign pkt_count     = pkt_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_opp_packet_decoder.sv
// Scoreboard bench for opp_packet_decoder: random and directed packets
// against a behavioural model of link, counters and reset confirmation.
`timescale 1ns/1ps
module tb_opp_packet_decoder;

  localparam int T  = 16;
  localparam int RC = 2;

  logic        clk, rst_n, axiov;
  logic [43:0] axiod;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_valid, link_lost, new_pulse, opp_reset_req;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  opp_packet_decoder #(
    .TIMEOUT_CYCLES(T),
    .RESET_CONFIRM (RC)
  ) dut (
    .clk_in       (clk),
    .rst_in_n     (rst_n),
    .axiov        (axiov),
    .axiod        (axiod),
    .opp_x        (opp_x),
    .opp_y        (opp_y),
    .opp_dir      (opp_dir),
    .opp_game     (opp_game),
    .opp_valid    (opp_valid),
    .link_lost    (link_lost),
    .new_pulse    (new_pulse),
    .opp_reset_req(opp_reset_req),
    .pkt_count    (pkt_count),
    .err_count    (err_count)
  );

  typedef struct {
    int x, y, d, g;
    bit v, l, np, rr;
    int pc, ec;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int m_x, m_y, m_d, m_g, m_pc, m_ec, ones;
  bit ever;
  longint cyc, last;
  logic [43:0] last_good;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, queue=%0d", sb.size());
    $fatal(1, "timeout");
  end

  function automatic logic [43:0] mk(int x, int y, int d, int g,
                                     bit f, int rbit);
    logic [43:0] r;
    r = '0;
    r[43:33] = 11'(x);
    r[31:21] = 11'(y);
    r[19:11] = 9'(d);
    r[7:5]   = 3'(g);
    r[3]     = f;
    if (rbit >= 0) r[rbit] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_d = 0; m_g = 0;
    m_pc = 0; m_ec = 0; ones = 0;
    ever = 0; last = 0;
  endtask

  task automatic model(input bit v, input logic [43:0] d);
    int x, y, di, g;
    bit f, rz, ok;
    exp_t e;
    cyc++;
    x  = int'(d[43:33]);
    y  = int'(d[31:21]);
    di = int'(d[19:11]);
    g  = int'(d[7:5]);
    f  = d[3];
    rz = !d[32] && !d[20] && d[10:8] == 0 && !d[4] && d[2:0] == 0;
    ok = v && rz && x < 1024 && y < 768 && di < 360;
    e.np = 0;
    e.rr = 0;
    if (v && !ok && m_ec < 255) m_ec++;
    if (ok) begin
      e.np = (x != m_x) || (y != m_y) || (di != m_d) || (g != m_g);
      m_x = x; m_y = y; m_d = di; m_g = g;
      m_pc = (m_pc + 1) % 65536;
      ever = 1;
      last = cyc;
      if (f) begin
        ones++;
        e.rr = (ones == RC);
      end else begin
        ones = 0;
      end
    end
    e.x = m_x; e.y = m_y; e.d = m_d; e.g = m_g;
    e.l = ever && (cyc - last) >= T;
    e.v = ever && !e.l;
    e.pc = m_pc;
    e.ec = m_ec;
    sb.push_back(e);
  endtask

  task automatic apply(input bit v, input logic [43:0] d);
    axiov = v;
    axiod = d;
    model(v, d);
  endtask

  task automatic step(input bit v, input logic [43:0] d);
    @(negedge clk);
    apply(v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (opp_x != 0 || opp_y != 0 || opp_dir != 0 || opp_game != 0 ||
        opp_valid || link_lost || new_pulse || opp_reset_req ||
        pkt_count != 0 || err_count != 0) begin
      miscompares++;
      $display("FAIL %s: x=%0d y=%0d dir=%0d g=%0d v=%b l=%b np=%b rr=%b pc=%0d ec=%0d, required all 0",
               tag, opp_x, opp_y, opp_dir, opp_game, opp_valid,
               link_lost, new_pulse, opp_reset_req, pkt_count,
               err_count);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (int'(opp_x) != e.x || int'(opp_y) != e.y ||
            int'(opp_dir) != e.d || int'(opp_game) != e.g ||
            opp_valid != e.v || link_lost != e.l ||
            new_pulse != e.np || opp_reset_req != e.rr ||
            int'(pkt_count) != e.pc || int'(err_count) != e.ec) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got x=%0d y=%0d d=%0d g=%0d v=%b l=%b np=%b rr=%b pc=%0d ec=%0d; required x=%0d y=%0d d=%0d g=%0d v=%b l=%b np=%b rr=%b pc=%0d ec=%0d",
                   $time, opp_x, opp_y, opp_dir, opp_game, opp_valid,
                   link_lost, new_pulse, opp_reset_req, pkt_count,
                   err_count, e.x, e.y, e.d, e.g, e.v, e.l, e.np,
                   e.rr, e.pc, e.ec);
        end
      end
    end
  end

  initial begin
    int kind, x, y, d, g, rb;
    int rbits[9] = '{32, 20, 10, 9, 8, 4, 2, 1, 0};
    bit f;
    rst_n = 1'b0;
    axiov = 1'b0;
    axiod = '0;
    cyc = 0;
    model_reset();
    last_good = '0;
    #1;
    check_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, '0);

    // basic accept, rejects, boundaries
    step(1'b1, mk(100, 200, 90, 3, 0, -1));
    step(1'b1, mk(100, 200, 360, 3, 0, -1));
    step(1'b1, mk(100, 200, 90, 3, 0, 0));
    step(1'b1, mk(1023, 767, 359, 7, 0, -1));
    step(1'b1, mk(1024, 5, 5, 1, 0, -1));
    step(1'b1, mk(5, 768, 5, 1, 0, -1));
    for (int i = 0; i < 9; i++) step(1'b1, mk(1, 2, 3, 1, 0, rbits[i]));
    step(1'b1, mk(1023, 767, 359, 7, 0, -1));

    // timeout, expiry-cycle packet, then real loss and recovery
    idle(T - 1);
    step(1'b1, mk(1023, 767, 359, 7, 0, -1));
    idle(T + 3);
    step(1'b1, mk(10, 20, 30, 2, 0, -1));

    // reset confirmation streaks
    step(1'b1, mk(10, 20, 30, 2, 1, -1));
    step(1'b1, mk(10, 20, 30, 2, 1, -1));
    step(1'b1, mk(10, 20, 30, 2, 1, -1));
    step(1'b1, mk(10, 20, 30, 2, 0, -1));
    step(1'b1, mk(10, 20, 30, 2, 1, -1));
    step(1'b1, mk(10, 20, 30, 2, 1, -1));
    step(1'b1, mk(11, 20, 30, 2, 0, -1));
    step(1'b1, mk(11, 20, 30, 2, 1, -1));
    step(1'b1, mk(11, 20, 400, 2, 1, -1));
    step(1'b1, mk(11, 20, 30, 2, 1, -1));

    // randomized traffic
    last_good = mk(11, 20, 30, 2, 1, -1);
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 9);
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 767);
      d = $urandom_range(0, 359);
      g = $urandom_range(0, 7);
      f = 1'($urandom_range(0, 1));
      if (kind <= 4) begin
        last_good = mk(x, y, d, g, f, -1);
        step(1'b1, last_good);
      end else if (kind == 5) begin
        step(1'b1, last_good);
      end else if (kind == 6) begin
        rb = $urandom_range(0, 3);
        if (rb == 0) x = $urandom_range(1024, 2047);
        if (rb == 1) y = $urandom_range(768, 2047);
        if (rb == 2) d = $urandom_range(360, 511);
        step(1'b1, mk(x, y, d, g, f,
                      rb == 3 ? rbits[$urandom_range(0, 8)] : -1));
      end else begin
        idle($urandom_range(1, 20));
      end
    end

    // error counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, mk(1, 1, 360, 0, 0, -1));

    // packet counter wrap
    while (m_pc != 65535)
      step(1'b1, mk(m_pc % 1024, 7, 8, 1, 0, -1));
    step(1'b1, mk(500, 7, 8, 1, 0, -1));
    step(1'b1, mk(500, 7, 8, 1, 0, -1));

    // async reset in LINKED, coincident packet discarded
    step(1'b1, mk(300, 300, 300, 5, 0, -1));
    @(negedge clk);
    axiov = 1'b1;
    axiod = mk(77, 77, 77, 1, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, '0);
    step(1'b1, mk(100, 200, 90, 3, 0, -1));
    idle(2);

    repeat (4) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: queue=%0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
